matrix_mac_stream: RTL and testbench
====================================

# matrix_mac_stream

Parametrised streaming matrix multiply-accumulate engine: accumulates C += A·B for DIM×DIM tiles by accepting one outer-product beat (column k of A, row k of B) per cycle, then drains the accumulator one row per beat over a valid/ready output. It succeeds the fixed 4×4 MAC unit in the compute datapath. It adds configurable dimension and widths, signed/unsigned mode, saturating accumulation, and backpressured result readout.

## Interface
- DATA_WIDTH, 8, operand element width
- ACC_WIDTH, 24, accumulator/result element width (must be ≥ 2·DATA_WIDTH)
- DIM, 4, matrix dimension (2..16)
- SIGNED, 1, 1 = two's-complement operands/accumulators, 0 = unsigned
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous zeroing of all accumulators and overflow (ACCUM state only)
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts a beat
- in_last  in  1  final beat of the tile
- a_col  in  DIM·DATA_WIDTH  A column; element i at [i·DATA_WIDTH +: DATA_WIDTH]
- b_row  in  DIM·DATA_WIDTH  B row; element j at same packing
- hold_acc  in  1  sampled at drain completion: 1 = keep accumulators for next tile
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts row
- out_row  out  DIM·ACC_WIDTH  C row r; element j at [j·ACC_WIDTH +: ACC_WIDTH]
- out_idx  out  $clog2(DIM)  row index r
- out_last  out  1  high with row DIM-1
- overflow  out  1  sticky: some accumulator saturated since last clear

## Operation
- States: ACCUM (in_ready=1, out_valid=0), DRAIN (in_ready=0, out_valid=1).
- ACCUM, beat accepted (in_valid & in_ready): acc[i][j] <= sat(acc[i][j] + a_col[i]·b_row[j]) for all i, j.
- Product: 2·DATA_WIDTH bits, sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH+1; sum clamped to [min, max] of ACC_WIDTH (signed or unsigned); any clamp sets overflow.
- clear in ACCUM: acc and overflow zero. clear with an accepted beat in the same cycle gives acc = product (clear first, then add). clear is ignored in DRAIN.
- Accepted beat with in_last moves to DRAIN, with r = 0.
- DRAIN: out_row = acc row r. Each out_valid & out_ready increments r. The handshake at r = DIM-1 returns to ACCUM.
  - hold_acc = 0 at that handshake: acc and overflow zeroed.
  - hold_acc = 1: acc and overflow retained.
- Outputs are stable while out_valid & !out_ready.
- No tile beat count is enforced; any number ≥1 of beats before in_last is legal.

## Timing
- Reset values: state ACCUM, all acc 0, in_ready 1, out_valid 0, out_row 0, out_idx 0, out_last 0, overflow 0. Applies immediately on reset assertion, including mid-drain; any partial tile is discarded.
- Beat accepted in cycle t: acc updated at the end-of-t edge.
- in_last accepted in cycle t: out_valid = 1 in t+1 with row 0.
- With out_ready held high, rows 0..DIM-1 appear in t+1..t+DIM, and in_ready = 1 again in t+DIM+1.
- Zero-bubble output under continuous out_ready; one row per handshake.
- overflow updates in the same edge as the saturating accumulate.

## Structure
- Package matrix_mac_pkg:
  - state enum {ACCUM, DRAIN}
  - function sat_add(acc, prod, signed_mode) returning {clamped value, ovf}
  - localparams for default widths
- Sub-module mac_cell: one accumulator element (extend, add, saturate, clear/zero, hold). Instantiated DIM×DIM by generate; the top holds the FSM, row counter, output mux and overflow OR-reduction.

## Test plan
- DIM=4, SIGNED=1: stream identity (a_col = e_k, b_row = row k of B, in_last on k=3), B[i][j]=i·4+j → rows out 0..3 equal B, out_last on idx 3, in_ready back 5 cycles after last.
- Signed single beat a_col={-3,2,-128,127}, b_row={5,-1,-128,1} → C[2][2]=16384, C[0][0]=-15, C[3][1]=-127; SIGNED=0 rerun gives unsigned products (e.g. 253·5=1265).
- Saturation, ACC_WIDTH=16 signed: 3 beats of 127·127 into C[0][0] → 32767, overflow=1; next tile with hold_acc=0 → overflow=0.
- Backpressure: out_ready toggled 1,0,0,1,… during drain → each row held stable while stalled, out_idx strictly 0,1,2,3, no rows skipped or repeated, in_ready stays 0 until last handshake.
- clear with beat same cycle after prior accumulation of 50 → acc = new product only. hold_acc=1 across two identical tiles → second drain shows 2× first.
- Reset asserted mid-drain (after row 1) → out_valid, outputs and overflow 0 immediately. A following 1-beat tile produces a fresh, uncontaminated result.

Source files
------------

// File: rtl/matrix_mac_stream_pkg.sv
// Shared types and the saturating-add helper for the streaming matrix MAC engine.
// Saturation works in a 64-bit signed domain, so ACC_WIDTH must stay well below 64.
package matrix_mac_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_DIM        = 4;
  localparam int DEF_SIGNED     = 1;
  localparam int SAT_W          = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  typedef enum logic {ACCUM, DRAIN} state_t;

  typedef struct packed {
    wide_t value;
    logic  ovf;
  } sat_t;

  // Operands arrive already extended to SAT_W, so the raw sum cannot wrap.
  function automatic sat_t sat_add(input wide_t acc, input wide_t prod,
                                   input int acc_w, input logic signed_mode);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    sat_t  res;
    sum = acc + prod;
    if (signed_mode) begin
      hi = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (acc_w - 1));
    end else begin
      hi = (wide_t'(1) <<< acc_w) - wide_t'(1);
      lo = '0;
    end
    res.value = sum;
    res.ovf   = 1'b0;
    if (sum > hi) begin
      res.value = hi;
      res.ovf   = 1'b1;
    end else if (sum < lo) begin
      res.value = lo;
      res.ovf   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/matrix_mac_stream_if.sv
// Beat input and row output bundle of the streaming matrix MAC engine.
interface matrix_mac_stream_if
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DIM        = DEF_DIM
) ();

  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [DIM*DATA_WIDTH-1:0] a_col;
  logic [DIM*DATA_WIDTH-1:0] b_row;
  logic                      clear;
  logic                      hold_acc;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIM*ACC_WIDTH-1:0]  out_row;
  logic [IDX_W-1:0]          out_idx;
  logic                      out_last;
  logic                      overflow;

  modport master (
    output in_valid, in_last, a_col, b_row, clear, hold_acc, out_ready,
    input  in_ready, out_valid, out_row, out_idx, out_last, overflow
  );

  modport slave (
    input  in_valid, in_last, a_col, b_row, clear, hold_acc, out_ready,
    output in_ready, out_valid, out_row, out_idx, out_last, overflow
  );

endinterface

// File: rtl/matrix_mac_stream_cell.sv
// One accumulator element: extend the product, add, saturate, and keep a sticky
// overflow flag. zero wipes the element; with en it acts before the add.
module mac_cell
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SIGNED     = DEF_SIGNED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  zero,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf
);

  localparam logic SMODE = (SIGNED != 0);

  logic signed [2*DATA_WIDTH-1:0] prod;
  wide_t                          prod_ext;
  wide_t                          base_ext;
  sat_t                           sum;

  // Operands widened to 2*DATA_WIDTH first so one signed multiply serves both modes.
  always_comb begin
    prod = $signed({{DATA_WIDTH{SMODE & a[DATA_WIDTH-1]}}, a}) *
           $signed({{DATA_WIDTH{SMODE & b[DATA_WIDTH-1]}}, b});
    prod_ext = {{(SAT_W-2*DATA_WIDTH){SMODE & prod[2*DATA_WIDTH-1]}}, prod};
    base_ext = zero ? '0 : {{(SAT_W-ACC_WIDTH){SMODE & acc[ACC_WIDTH-1]}}, acc};
    sum      = sat_add(base_ext, prod_ext, ACC_WIDTH, SMODE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum.value[ACC_WIDTH-1:0];
      ovf <= (ovf & ~zero) | sum.ovf;
    end else if (zero) begin
      acc <= '0;
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_mac_stream.sv
// Streaming DIMxDIM multiply-accumulate: one outer-product beat per cycle in ACCUM,
// then one accumulator row per valid/ready handshake in DRAIN.
module matrix_mac_stream
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DIM        = DEF_DIM,
  parameter int SIGNED     = DEF_SIGNED
) (
  input logic               clk,
  input logic               rst_n,
  matrix_mac_stream_if.slave bus
);

  localparam int               IDX_W    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(DIM - 1);

  state_t               state_q;
  state_t               state_d;
  logic [IDX_W-1:0]     row_q;
  logic [IDX_W-1:0]     row_d;
  logic                 accept;
  logic                 row_hs;
  logic                 drain_done;
  logic                 acc_zero;
  logic [ACC_WIDTH-1:0] acc [DIM][DIM];
  logic [DIM*DIM-1:0]   cell_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    accept     = (state_q == ACCUM) && bus.in_valid;
    row_hs     = (state_q == DRAIN) && bus.out_ready;
    drain_done = row_hs && (row_q == LAST_ROW);
    unique case (state_q)
      ACCUM: begin
        if (accept && bus.in_last) begin
          state_d = DRAIN;
          row_d   = '0;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = ACCUM;
          row_d   = '0;
        end else if (row_hs) begin
          row_d = row_q + 1'b1;
        end
      end
    endcase
  end

  // clear only counts in ACCUM; a drain without hold_acc wipes the tile on exit.
  assign acc_zero = ((state_q == ACCUM) && bus.clear) || (drain_done && !bus.hold_acc);

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      mac_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED)
      ) u_cell (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .zero (acc_zero),
        .a    (bus.a_col[i*DATA_WIDTH +: DATA_WIDTH]),
        .b    (bus.b_row[j*DATA_WIDTH +: DATA_WIDTH]),
        .acc  (acc[i][j]),
        .ovf  (cell_ovf[i*DIM + j])
      );
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_idx   = row_q;
  assign bus.out_last  = (state_q == DRAIN) && (row_q == LAST_ROW);
  assign bus.overflow  = |cell_ovf;

  always_comb begin
    bus.out_row = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < DIM; j++) begin
        bus.out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
      end
    end
  end

endmodule

// File: tb/tb_matrix_mac_stream.sv
// Three engines (signed/24, unsigned/24, signed/16) share one random beat stream;
// a plain-arithmetic matrix model feeds a row scoreboard checked by a monitor.
module tb_matrix_mac_stream;
  import matrix_mac_pkg::*;

  localparam int DW = 8, DIM = 4, NC = 3;
  localparam int AW0 = 24, AW1 = 24, AW2 = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                in_valid = 0, in_last = 0, clear = 0, hold_acc = 0, out_ready = 1;
  logic [DIM*DW-1:0]   a_col = '0, b_row = '0;

  matrix_mac_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW0), .DIM(DIM)) bus0 ();
  matrix_mac_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW1), .DIM(DIM)) bus1 ();
  matrix_mac_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW2), .DIM(DIM)) bus2 ();

  assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid; assign bus2.in_valid = in_valid;
  assign bus0.in_last  = in_last;  assign bus1.in_last  = in_last;  assign bus2.in_last  = in_last;
  assign bus0.a_col    = a_col;    assign bus1.a_col    = a_col;    assign bus2.a_col    = a_col;
  assign bus0.b_row    = b_row;    assign bus1.b_row    = b_row;    assign bus2.b_row    = b_row;
  assign bus0.clear    = clear;    assign bus1.clear    = clear;    assign bus2.clear    = clear;
  assign bus0.hold_acc = hold_acc; assign bus1.hold_acc = hold_acc; assign bus2.hold_acc = hold_acc;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;

  matrix_mac_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW0), .DIM(DIM), .SIGNED(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  matrix_mac_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW1), .DIM(DIM), .SIGNED(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  matrix_mac_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW2), .DIM(DIM), .SIGNED(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [NC-1:0]                 g_vld, g_rdy, g_last, g_ovf;
  logic [NC-1:0][1:0]            g_idx;
  logic [NC-1:0][DIM-1:0][63:0]  g_row;

  always_comb begin
    g_vld  = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    g_rdy  = {bus2.in_ready,  bus1.in_ready,  bus0.in_ready};
    g_last = {bus2.out_last,  bus1.out_last,  bus0.out_last};
    g_ovf  = {bus2.overflow,  bus1.overflow,  bus0.overflow};
    g_idx  = {bus2.out_idx,   bus1.out_idx,   bus0.out_idx};
    for (int j = 0; j < DIM; j++) begin
      g_row[0][j] = 64'($signed(bus0.out_row[j*AW0 +: AW0]));
      g_row[1][j] = 64'(bus1.out_row[j*AW1 +: AW1]);
      g_row[2][j] = 64'($signed(bus2.out_row[j*AW2 +: AW2]));
    end
  end

  typedef struct packed {
    logic [NC-1:0][DIM-1:0][63:0] v;
    logic [NC-1:0]                ovf;
    logic [1:0]                   idx;
    logic                         last;
  } exp_t;

  exp_t        exp_q[$];
  longint      mdl [NC][DIM][DIM];
  bit [NC-1:0] mdl_ovf;
  int          n_chk = 0, n_fail = 0;
  int          rdy_mode = 0, cyc = 0;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout_fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  function automatic void model_zero();
    mdl_ovf = '0;
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) mdl[c][i][j] = 0;
  endfunction

  function automatic longint elem(logic [DIM*DW-1:0] v, int i, bit sgn);
    logic [DW-1:0] e;
    e = v[i*DW +: DW];
    return sgn ? longint'($signed(e)) : longint'(e);
  endfunction

  // C += a * b^T per configuration, clamped to that configuration's range.
  function automatic void model_beat(logic [DIM*DW-1:0] a, logic [DIM*DW-1:0] b, bit clr);
    longint s, lo, hi;
    bit     sgn;
    int     aw;
    if (clr) model_zero();
    for (int c = 0; c < NC; c++) begin
      sgn = (c != 1);
      aw  = (c == 2) ? AW2 : AW0;
      hi  = sgn ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
      lo  = sgn ? -(longint'(1) << (aw - 1)) : 0;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          s = mdl[c][i][j] + elem(a, i, sgn) * elem(b, j, sgn);
          if (s > hi) begin s = hi; mdl_ovf[c] = 1'b1; end
          if (s < lo) begin s = lo; mdl_ovf[c] = 1'b1; end
          mdl[c][i][j] = s;
        end
    end
  endfunction

  function automatic void model_push(bit hld);
    exp_t e;
    for (int r = 0; r < DIM; r++) begin
      e.idx  = 2'(r);
      e.last = (r == DIM - 1);
      e.ovf  = mdl_ovf;
      for (int c = 0; c < NC; c++)
        for (int j = 0; j < DIM; j++) e.v[c][j] = mdl[c][r][j];
      exp_q.push_back(e);
    end
    if (!hld) model_zero();
  endfunction

  // Presents one beat once the engine is accepting; returns just after its accepting edge.
  task automatic beat(input logic [DIM*DW-1:0] a, input logic [DIM*DW-1:0] b,
                      input bit last, input bit clr, input bit hld);
    int waited = 0;
    while (bus0.in_ready !== 1'b1) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin timeout_fail("beat_in_ready"); return; end
    end
    in_valid = 1; a_col = a; b_row = b; in_last = last; clear = clr;
    if (last) hold_acc = hld;
    @(posedge clk);
    model_beat(a, b, clr);
    if (last) model_push(hld);
    #1;
    in_valid = 0; in_last = 0; clear = 0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (exp_q.size() != 0 || bus0.in_ready !== 1'b1) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 300) begin timeout_fail("drain_done"); return; end
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_out_valid"}, g_vld, '0);
    check({tag, "_in_ready"},  g_rdy, 3'b111);
    check({tag, "_out_idx"},   g_idx, '0);
    check({tag, "_out_last"},  g_last, '0);
    check({tag, "_overflow"},  g_ovf, '0);
    for (int c = 0; c < NC; c++) check($sformatf("%s_out_row%0d", tag, c), g_row[c], '0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc % 3 == 0);
      endcase
    end
  end

  // Monitor: compares the queue head every cycle so stalled rows must hold still.
  exp_t hd;
  bit   busy;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        busy = (exp_q.size() != 0);
        check("in_ready", g_rdy, busy ? 3'b000 : 3'b111);
        check("out_valid", g_vld, busy ? 3'b111 : 3'b000);
        if (busy) begin
          hd = exp_q[0];
          for (int c = 0; c < NC; c++) check($sformatf("row_cfg%0d_idx%0d", c, hd.idx), g_row[c], hd.v[c]);
          check("out_idx", g_idx, {NC{hd.idx}});
          check("out_last", g_last, {NC{hd.last}});
          check("overflow_drain", g_ovf, hd.ovf);
          if (out_ready) void'(exp_q.pop_front());
        end else begin
          check("overflow_idle", g_ovf, mdl_ovf);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DIM*DW-1:0] a, b;
    int n, nb;
    model_zero();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Identity columns against B[i][j] = 4i+j; drain must mirror B.
    for (int k = 0; k < DIM; k++) begin
      a = '0; a[k*DW +: DW] = 8'd1;
      for (int j = 0; j < DIM; j++) b[j*DW +: DW] = 8'(k*DIM + j);
      beat(a, b, k == DIM - 1, 0, 0);
    end
    n = 0;
    while (bus0.in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    // ready again in cycle t+DIM+1, i.e. DIM edges after the accepting one
    check("in_ready_latency", n, DIM);
    wait_drain();

    // Mixed-sign single beat: a={-3,2,-128,127}, b={5,-1,-128,1}.
    beat({8'd127, 8'h80, 8'd2, 8'hFD}, {8'd1, 8'hFF, 8'h80, 8'd5}, 1, 0, 0);
    wait_drain();

    // 3 x 127*127 saturates the 16-bit engine only; next tile sees overflow cleared.
    for (int k = 0; k < 3; k++) beat(32'd127, 32'd127, k == 2, 0, 0);
    wait_drain();
    beat($urandom(), $urandom(), 1, 0, 0);
    wait_drain();

    // Backpressure 1,0,0 pattern; clear held during drain must be ignored (hold_acc=1).
    rdy_mode = 2;
    beat($urandom(), $urandom(), 0, 0, 0);
    beat($urandom(), $urandom(), 1, 0, 1);
    clear = 1;
    wait_drain();
    clear = 0;
    rdy_mode = 0;
    beat($urandom(), $urandom(), 1, 0, 0);
    wait_drain();

    // Accumulate 50, then clear together with a beat: result is that beat alone.
    beat(32'd5, 32'd10, 0, 0, 0);
    beat($urandom(), $urandom(), 1, 1, 0);
    wait_drain();

    // Two identical tiles with hold_acc=1 on the first: second drain doubles.
    a = $urandom(); b = $urandom();
    beat(a, b, 1, 0, 1);
    wait_drain();
    beat(a, b, 1, 0, 0);
    wait_drain();

    for (int t = 0; t < 12; t++) begin
      rdy_mode = $urandom_range(0, 2);
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++)
        beat($urandom(), $urandom(), k == nb - 1, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rdy_mode = 0;

    // Reset after two rows of a saturating tile; everything must vanish at once.
    for (int k = 0; k < 3; k++) beat(32'd127, 32'd127, k == 2, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_idx", g_idx, {NC{2'd2}});
    check("pre_reset_ovf", g_ovf, 3'b100);
    rst_n = 0;
    #1;
    check_reset_outputs("mid_drain_reset");
    exp_q.delete();
    model_zero();
    hold_acc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    beat($urandom(), $urandom(), 1, 0, 0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
